trace_stack: RTL

Parametrised assignment trail for the DPLL solver core: a LIFO of variable assignments tagged as decision or forced (implied). It replaces the single-entry push/pop trace table. It adds full/overflow detection, a decision-level counter, and a hardware backtrack command that unwinds the trail to the most recent decision and re-pushes its complement as a forced assignment. It sits between the decision/BCP controller and the variable-assignment store; every popped entry is streamed out so the assignment store can clear it.

---
 rtl/trace_stack_if.sv | 37 +++
 rtl/trace_stack.sv | 89 ++++++++
 2 files changed

// File: rtl/trace_stack_if.sv
// trace_stack_if: command/status bundle between the DPLL controller and the assignment trail
interface trace_stack_if #(
  parameter int VAR_W = 9,
  parameter int CNT_W = 8
);
  logic             push;
  logic             push_type;
  logic             push_val;
  logic [VAR_W-1:0] push_var;
  logic             pop;
  logic             backtrack;
  logic             ready;
  logic             pop_valid;
  logic             pop_type;
  logic             pop_val;
  logic [VAR_W-1:0] pop_var;
  logic             top_type;
  logic             top_val;
  logic [VAR_W-1:0] top_var;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] level;
  logic             empty;
  logic             full;
  logic             bt_done;
  logic             bt_unsat;
  logic             err;
  modport master (
    output push, push_type, push_val, push_var, pop, backtrack,
    input  ready, pop_valid, pop_type, pop_val, pop_var, top_type, top_val, top_var,
           count, level, empty, full, bt_done, bt_unsat, err
  );
  modport slave (
    input  push, push_type, push_val, push_var, pop, backtrack,
    output ready, pop_valid, pop_type, pop_val, pop_var, top_type, top_val, top_var,
           count, level, empty, full, bt_done, bt_unsat, err
  );
endinterface

// File: rtl/trace_stack.sv
// trace_stack: DPLL assignment trail with hardware backtrack; TRACE_STACK_LEVEL_EN builds the decision-level counter
module trace_stack #(
  parameter int DEPTH = 128,
  parameter int VAR_W = 9,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          reset,
  trace_stack_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0, UNWIND = 1'b1;
  localparam int EW = VAR_W + 2;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [EW-1:0] stack [DEPTH];
  logic [0:0] state;
  logic [CNT_W-1:0] count, level;
  logic [EW-1:0] top, pop_entry;
  logic [AW-1:0] top_idx;
  logic empty, full, idle, unw;
  logic do_bt, do_pop, do_push, wr, rm, unw_pop, unw_flip, unw_unsat;
  logic pop_valid, bt_done, bt_unsat, err;
  // command decode: backtrack beats pop beats push, and only IDLE accepts anything
  always_comb begin
    empty = count == '0;
    full = count == CNT_W'(DEPTH);
    top_idx = AW'(count - CNT_W'(1));
    top = empty ? '0 : stack[top_idx];
    idle = state == IDLE;
    unw = state == UNWIND;
    do_bt = idle & bus.backtrack;
    do_pop = idle & ~bus.backtrack & bus.pop;
    do_push = idle & ~bus.backtrack & ~bus.pop & bus.push;
    wr = do_push & ~full;
    unw_unsat = unw & empty;
    unw_pop = unw & ~empty & top[EW-1];
    unw_flip = unw & ~empty & ~top[EW-1];
    rm = (do_pop & ~empty) | unw_pop;
  end
  // control state, pointer and registered pop/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      pop_valid <= 1'b0;
      pop_entry <= '0;
      bt_done <= 1'b0;
      bt_unsat <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= do_bt ? UNWIND : (unw_flip | unw_unsat) ? IDLE : state;
      count <= wr ? count + CNT_W'(1) : rm ? count - CNT_W'(1) : count;
      pop_valid <= rm | unw_flip;
      if (rm | unw_flip) pop_entry <= top;
      bt_done <= unw_flip;
      bt_unsat <= unw_unsat;
      err <= err | (do_push & full) | (do_pop & empty);
    end
  end
  // trail storage: push appends, a backtrack flip rewrites the decision as its forced complement
  always_ff @(posedge clk) begin
    if (wr) stack[AW'(count)] <= {bus.push_type, bus.push_val, bus.push_var};
    else if (unw_flip) stack[top_idx] <= {1'b1, ~top[EW-2], top[VAR_W-1:0]};
  end
`ifdef TRACE_STACK_LEVEL_EN
  // decision level tracks decisions held; floor at zero keeps it from wrapping
  always_ff @(posedge clk) begin
    if (reset) level <= '0;
    else if (wr & ~bus.push_type) level <= level + CNT_W'(1);
    else if (((rm & ~top[EW-1]) | unw_flip) & (level != '0)) level <= level - CNT_W'(1);
  end
`else
  assign level = '0;
`endif
  assign bus.ready = idle;
  assign bus.pop_valid = pop_valid;
  assign bus.pop_type = pop_entry[EW-1];
  assign bus.pop_val = pop_entry[EW-2];
  assign bus.pop_var = pop_entry[VAR_W-1:0];
  assign bus.top_type = top[EW-1];
  assign bus.top_val = top[EW-2];
  assign bus.top_var = top[VAR_W-1:0];
  assign bus.count = count;
  assign bus.level = level;
  assign bus.empty = empty;
  assign bus.full = full;
  assign bus.bt_done = bt_done;
  assign bus.bt_unsat = bt_unsat;
  assign bus.err = err;
endmodule
